fm_sb_capture_ctrl: RTL
=======================

# fm_sb_capture_ctrl

Capture and playback sequencer for one floating-monitor spy buffer. It drives the spy-buffer memory write port from the monitored stream (`fm_data`/`fm_vld`) and freezes the buffer a programmable number of words after a trigger. On freeze it writes a metadata word to the spy-meta memory, then optionally replays the frozen contents in chronological order. One instance sits beside each of the `total_sb` spy buffers, between the AXI control registers and the buffer's dual-port memory.

## Interface
Parameters:
- `SB_ADDR_W`, 10: spy-buffer address width; depth is 2^`SB_ADDR_W`; legal range 2..16.
- `POST_W`, 16: width of the post-trigger word counter.
- `PB_MODE_W`, 2: playback-mode field width, equal to `pb_mode_width`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, asynchronous and active-low.
- `mon_vld` in 1: monitored word valid (`fm_rt.fm_vld`).
- `trig` in 1: freeze trigger, level-sampled each cycle.
- `arm` in 1: single-cycle pulse from control registers that (re)starts capture.
- `pb_mode` in `PB_MODE_W`: 00 = capture-stop, 01 = continuous (no freeze), 10 = playback-once, 11 = playback-loop.
- `post_trig_cnt` in `POST_W`: number of words to capture after the trigger word.
- `pb_start` in 1: single-cycle pulse that requests playback.
- `pb_ready` in 1: downstream can accept one playback word.
- `sb_wr_en` out 1, `sb_wr_addr` out `SB_ADDR_W`: spy-buffer write port (data path bypasses this block).
- `sb_rd_en` out 1, `sb_rd_addr` out `SB_ADDR_W`: spy-buffer playback read port.
- `pb_vld` out 1: playback word on the memory output is valid.
- `meta_wr_en` out 1, `meta_wr_data` out `axi_dw` (32): metadata write.
- `frozen` out 1: high in the FROZEN state.
- `state` out 3: state encoding for `FM_MON` status.

## Operation
- States: IDLE=0, ARMED=1, POST=2, FROZEN=3, PLAY=4.
- IDLE: no memory activity. `arm` moves to ARMED, clears `wr_ptr` to 0 and clears `wrapped`.
- ARMED:
  - Every `mon_vld` asserts `sb_wr_en` at `wr_ptr`, then increments `wr_ptr` modulo depth.
  - `wrapped` sets when the pointer moves from depth-1 to 0.
  - `trig` with `pb_mode`≠01 moves to POST and loads `cnt`=`post_trig_cnt`. A word arriving in the trigger cycle is written and is not counted.
  - If `post_trig_cnt`=0, the block goes to FROZEN instead of POST.
  - In mode 01, `trig` is ignored.
- POST:
  - Each `mon_vld` writes and decrements `cnt`.
  - Writing with `cnt`=1 moves to FROZEN.
  - `trig` is ignored.
- FROZEN:
  - On entry, `meta_wr_en` pulses for one cycle.
  - `meta_wr_data` = {[31] `wrapped`, [30] 1 (trigger seen), [29:16] 0, [15:0] `wr_ptr` zero-extended}.
  - `pb_start` with `pb_mode`[1]=1 moves to PLAY.
- PLAY:
  - Start address is `wr_ptr` if `wrapped`, else 0. Length is depth if `wrapped`, else `wr_ptr`.
  - `sb_rd_en` asserts only when `pb_ready`=1. The address increments modulo depth after each read.
  - After the last read: mode 10 returns to FROZEN; mode 11 restarts from the start address.
  - If `pb_mode`[1] is cleared mid-play, the block finishes the current read and returns to FROZEN.
  - Empty buffer (length 0): PLAY returns to FROZEN the next cycle with no reads.
- `arm` has top priority in every state. It aborts POST, FROZEN or PLAY, clears pointers and enters ARMED. `arm` and `trig` in the same cycle: `arm` wins and `trig` is dropped.
- `pb_start` outside FROZEN is ignored.
- Memory contents are not cleared on `arm`; `wr_ptr` and `wrapped` define the valid region.

## Timing
- Reset (`rst_n` low, asynchronous): state=IDLE, `wr_ptr`=0, `cnt`=0, `wrapped`=0. All outputs are 0: `sb_wr_en`, `sb_wr_addr`, `sb_rd_en`, `sb_rd_addr`, `pb_vld`, `meta_wr_en`, `meta_wr_data`, `frozen`, `state`. Reset mid-capture or mid-play aborts immediately.
- `sb_wr_en`/`sb_wr_addr` are combinational from `mon_vld` and state, so the write lands in the same cycle `mon_vld` is high.
- `sb_rd_en`/`sb_rd_addr` are registered.
- Memory read latency is 1 cycle. `pb_vld` is `sb_rd_en` delayed by one cycle, independent of `pb_ready`.
- `meta_wr_en` asserts in the first FROZEN cycle. `frozen` rises in that same cycle.
- Freeze occurs on the cycle after the last post-trigger write.

## Structure
- Add to `fm_sb_pkg`: the state enum `fm_sb_state_t` and the pb_mode constants `PB_STOP`, `PB_CONT`, `PB_ONCE`, `PB_LOOP`.
- Meta field offsets go in the package as `META_WRAP_BIT`=31, `META_TRIG_BIT`=30, `META_PTR_LSB`=0.
- One instance per spy buffer, generated over `total_sb` in the FM top.
- One natural sub-module: `fm_sb_pb_reader`, which holds the playback address counter, length counter and `pb_vld` delay.

## Test plan
All scenarios use `SB_ADDR_W`=4 (depth 16).
- Arm, 5 `mon_vld` words, `trig` in word 5, `post_trig_cnt`=3, 3 more words:
  - `sb_wr_addr` runs 0..7.
  - FROZEN follows.
  - `meta_wr_data`=0x4000_0008.
- Arm, 20 words, then trig with `post_trig_cnt`=0:
  - Freeze with `wrapped`=1 and `wr_ptr`=4; meta=0xC000_0004.
  - Playback-once reads addresses 4..15, 0..3 (16 reads), then returns to FROZEN.
- Playback with `pb_ready` toggling 1,0,1,0:
  - `sb_rd_en` asserts only in ready cycles.
  - `pb_vld` follows `sb_rd_en` by exactly 1 cycle.
  - No address is skipped.
- Mode 01, 40 words with `trig` pulsed:
  - State stays ARMED; no `meta_wr_en`.
  - `sb_wr_addr` wraps to 0 after 15.
- `arm` and `trig` in the same cycle during POST: state becomes ARMED and the next write goes to address 0.
- `rst_n` asserted mid-PLAY: `sb_rd_en` and `pb_vld` drop at once and state=IDLE.
- Loop mode, buffer of 3 words: reads run 0,1,2,0,1,2.
- Empty buffer with `pb_start`: PLAY→FROZEN with 0 reads.

Source files
------------

// File: rtl/fm_sb_pkg.sv
// Shared types and constants for the floating-monitor spy-buffer capture controller.
package fm_sb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_POST   = 3'd2,
        ST_FROZEN = 3'd3,
        ST_PLAY   = 3'd4
    } fm_sb_state_t;

    localparam logic [1:0] PB_STOP = 2'b00;
    localparam logic [1:0] PB_CONT = 2'b01;
    localparam logic [1:0] PB_ONCE = 2'b10;
    localparam logic [1:0] PB_LOOP = 2'b11;

    localparam int unsigned AXI_DW        = 32;
    localparam int unsigned META_WRAP_BIT = 31;
    localparam int unsigned META_TRIG_BIT = 30;
    localparam int unsigned META_PTR_LSB  = 0;

    function automatic logic [AXI_DW-1:0] meta_word(input logic wrap, input logic [15:0] ptr);
        logic [AXI_DW-1:0] w;
        w = '0;
        w[META_WRAP_BIT]       = wrap;
        w[META_TRIG_BIT]       = 1'b1;
        w[META_PTR_LSB +: 16]  = ptr;
        return w;
    endfunction

endpackage

// File: rtl/fm_sb_capture_ctrl_pb_reader.sv
// Playback read sequencer: address/length counters and the one-cycle pb_vld delay
// matching the spy-buffer memory read latency.
module fm_sb_pb_reader
    import fm_sb_pkg::*;
#(
    parameter int unsigned SB_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 run,
    input  logic                 keep,
    input  logic                 loop,
    input  logic                 pb_ready,
    input  logic [SB_ADDR_W-1:0] start_addr,
    input  logic [SB_ADDR_W:0]   length,
    output logic                 rd_en,
    output logic [SB_ADDR_W-1:0] rd_addr,
    output logic                 pb_vld,
    output logic                 done
);

    logic [SB_ADDR_W-1:0] addr;
    logic [SB_ADDR_W-1:0] base;
    logic [SB_ADDR_W:0]   remain;
    logic [SB_ADDR_W:0]   span;
    logic                 fire;

    assign fire = run && keep && pb_ready && (remain != '0);
    assign done = run && (!keep || (remain == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            base    <= '0;
            remain  <= '0;
            span    <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            pb_vld  <= 1'b0;
        end else begin
            pb_vld <= rd_en;
            if (load) begin
                addr   <= start_addr;
                base   <= start_addr;
                remain <= length;
                span   <= length;
                rd_en  <= 1'b0;
            end else begin
                rd_en <= fire;
                if (fire) begin
                    rd_addr <= addr;
                    // Reload on the last read of a pass so looping has no idle gap.
                    if (loop && (remain == (SB_ADDR_W+1)'(1))) begin
                        addr   <= base;
                        remain <= span;
                    end else begin
                        addr   <= addr + SB_ADDR_W'(1);
                        remain <= remain - (SB_ADDR_W+1)'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fm_sb_capture_ctrl.sv
// Spy-buffer capture/freeze/playback sequencer: drives the buffer write port,
// freezes after a post-trigger count, logs metadata and replays chronologically.
module fm_sb_capture_ctrl
    import fm_sb_pkg::*;
#(
    parameter int unsigned SB_ADDR_W = 10,
    parameter int unsigned POST_W    = 16,
    parameter int unsigned PB_MODE_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mon_vld,
    input  logic                 trig,
    input  logic                 arm,
    input  logic [PB_MODE_W-1:0] pb_mode,
    input  logic [POST_W-1:0]    post_trig_cnt,
    input  logic                 pb_start,
    input  logic                 pb_ready,
    output logic                 sb_wr_en,
    output logic [SB_ADDR_W-1:0] sb_wr_addr,
    output logic                 sb_rd_en,
    output logic [SB_ADDR_W-1:0] sb_rd_addr,
    output logic                 pb_vld,
    output logic                 meta_wr_en,
    output logic [AXI_DW-1:0]    meta_wr_data,
    output logic                 frozen,
    output logic [2:0]           state
);

    localparam logic [SB_ADDR_W:0] DEPTH = {1'b1, {SB_ADDR_W{1'b0}}};

    fm_sb_state_t         cur_state, next_state;
    logic [SB_ADDR_W-1:0] wr_ptr, wr_ptr_next;
    logic                 wrapped, wrapped_next;
    logic [POST_W-1:0]    cnt, cnt_next;
    logic                 capture;
    logic                 meta_en_next;
    logic                 pb_keep, pb_loop;
    logic                 pb_load, pb_run, pb_done;
    logic [SB_ADDR_W-1:0] pb_start_addr;
    logic [SB_ADDR_W:0]   pb_length;

    // arm takes the cycle for itself: no write lands while pointers are being cleared.
    assign capture    = ((cur_state == ST_ARMED) || (cur_state == ST_POST)) && !arm;
    assign sb_wr_en   = capture && mon_vld;
    assign sb_wr_addr = wr_ptr;
    assign frozen     = (cur_state == ST_FROZEN);
    assign state      = cur_state;

    assign pb_keep       = pb_mode[1];
    assign pb_loop       = pb_mode[0];
    assign pb_load       = (cur_state == ST_FROZEN) && !arm && pb_start && pb_keep;
    assign pb_run        = (cur_state == ST_PLAY) && !arm;
    assign pb_start_addr = wrapped ? wr_ptr : '0;
    assign pb_length     = wrapped ? DEPTH : {1'b0, wr_ptr};

    always_comb begin
        next_state   = cur_state;
        wr_ptr_next  = wr_ptr;
        wrapped_next = wrapped;
        cnt_next     = cnt;
        if (sb_wr_en) begin
            wr_ptr_next = wr_ptr + SB_ADDR_W'(1);
            if (wr_ptr == '1) begin
                wrapped_next = 1'b1;
            end
        end
        if (arm) begin
            next_state   = ST_ARMED;
            wr_ptr_next  = '0;
            wrapped_next = 1'b0;
            cnt_next     = '0;
        end else begin
            case (cur_state)
                ST_ARMED: begin
                    if (trig && (pb_mode[1:0] != PB_CONT)) begin
                        if (post_trig_cnt == '0) begin
                            next_state = ST_FROZEN;
                        end else begin
                            next_state = ST_POST;
                            cnt_next   = post_trig_cnt;
                        end
                    end
                end
                ST_POST: begin
                    if (mon_vld) begin
                        cnt_next = cnt - POST_W'(1);
                        if (cnt == POST_W'(1)) begin
                            next_state = ST_FROZEN;
                        end
                    end
                end
                ST_FROZEN: begin
                    if (pb_load) begin
                        next_state = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (pb_done) begin
                        next_state = ST_FROZEN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Metadata is logged only for a capture freeze, not on return from playback.
    assign meta_en_next = (next_state == ST_FROZEN) && capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= ST_IDLE;
            wr_ptr       <= '0;
            wrapped      <= 1'b0;
            cnt          <= '0;
            meta_wr_en   <= 1'b0;
            meta_wr_data <= '0;
        end else begin
            cur_state  <= next_state;
            wr_ptr     <= wr_ptr_next;
            wrapped    <= wrapped_next;
            cnt        <= cnt_next;
            meta_wr_en <= meta_en_next;
            if (arm) begin
                meta_wr_data <= '0;
            end else if (meta_en_next) begin
                meta_wr_data <= meta_word(wrapped_next, 16'(wr_ptr_next));
            end
        end
    end

    fm_sb_pb_reader #(
        .SB_ADDR_W(SB_ADDR_W)
    ) u_pb_reader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pb_load),
        .run        (pb_run),
        .keep       (pb_keep),
        .loop       (pb_loop),
        .pb_ready   (pb_ready),
        .start_addr (pb_start_addr),
        .length     (pb_length),
        .rd_en      (sb_rd_en),
        .rd_addr    (sb_rd_addr),
        .pb_vld     (pb_vld),
        .done       (pb_done)
    );

endmodule
